// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose: shares one synchronous data-memory port between the CPU load/store
// unit and an ADC capture engine. Captured samples are queued in a small FIFO
// and written into a ring buffer in data memory at BUF_BASE.
//
// Optional feature macro: DMEM_ARB_FAIRNESS_EN
//   defined   - starvation counter; a pending DMA write is forced through after
//               MAX_STALL consecutive lost arbitration cycles.
//   undefined - strict CPU priority; DMA writes only in cycles with no cpu_req.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/wstrobe   CPU access request (held until granted)
//   cpu_gnt                    combinational grant, access issued this cycle
//   cpu_rvalid/cpu_rdata       load data, one cycle after a load grant
//   capture_en/adc_valid/adc_in     sample capture inputs
//   mem_en/rw/addr/wdata/wstrobe    memory port (combinational)
//   mem_rdata                  memory read data, one cycle after a read
//   fifo_level                 sample FIFO occupancy
//   wr_idx                     next ring slot to be written
//   overflow                   sticky: a sample was dropped
//   wrapped                    sticky: the ring has wrapped at least once
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter logic [31:0] BUF_BASE   = 32'h0000_0100,
    parameter int          BUF_WORDS  = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_STALL  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [31:0]                   cpu_addr,
    input  logic [31:0]                   cpu_wdata,
    input  logic [3:0]                    cpu_wstrobe,
    output logic                          cpu_gnt,
    output logic                          cpu_rvalid,
    output logic [31:0]                   cpu_rdata,
    input  logic                          capture_en,
    input  logic                          adc_valid,
    input  logic [31:0]                   adc_in,
    output logic                          mem_en,
    output logic                          mem_rw,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic [3:0]                    mem_wstrobe,
    input  logic [31:0]                   mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [$clog2(BUF_WORDS)-1:0]  wr_idx,
    output logic                          overflow,
    output logic                          wrapped
);

    localparam int IDX_W = $clog2(BUF_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // State
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             overflow_q, overflow_d;
    logic             wrapped_q, wrapped_d;
    logic             rvalid_q, rvalid_d;
    logic             capture_en_q;

    // Arbitration / FIFO control
    logic             dma_pending;
    logic             dma_wins;
    logic             cpu_wins;
    logic             sample;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             cap_rise;
    logic [31:0]      fifo_head;
    logic [31:0]      fifo_entries [FIFO_DEPTH];

    assign dma_pending = (level_q != '0);

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int STALL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    logic [STALL_W-1:0] stall_q, stall_d;

    // No grants are issued while reset is asserted so that nothing reaches
    // memory from a cycle whose state is about to be discarded.
    assign dma_wins = !reset && dma_pending &&
                      (!cpu_req || (stall_q == STALL_W'(MAX_STALL)));

    always_comb begin
        stall_d = stall_q;
        if (!dma_pending || dma_wins) begin
            stall_d = '0;
        end else if (stall_q != STALL_W'(MAX_STALL)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign dma_wins = !reset && dma_pending && !cpu_req;
`endif

    assign cpu_wins = !reset && cpu_req && !dma_wins;

    // Memory port mux; idle cycles drive all-zero outputs.
    always_comb begin
        mem_en      = 1'b0;
        mem_rw      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrobe = '0;
        if (cpu_wins) begin
            mem_en      = 1'b1;
            mem_rw      = cpu_we;
            mem_addr    = cpu_addr;
            mem_wdata   = cpu_wdata;
            mem_wstrobe = cpu_wstrobe;
        end else if (dma_wins) begin
            mem_en      = 1'b1;
            mem_rw      = 1'b1;
            mem_addr    = BUF_BASE + {{(30 - IDX_W){1'b0}}, wr_idx_q, 2'b00};
            mem_wdata   = fifo_head;
            mem_wstrobe = 4'hF;
        end
    end

    assign cpu_gnt    = cpu_wins;
    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rvalid_q ? mem_rdata : '0;

    // Sample FIFO: one register per entry, head read combinationally so the
    // DMA write can be issued in the same cycle it wins arbitration.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            logic [31:0] entry_q;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_q <= adc_in;
                end
            end
            assign fifo_entries[gi] = entry_q;
        end
    endgenerate

    assign fifo_head = fifo_entries[rd_ptr_q];
    assign sample    = capture_en && adc_valid;
    assign fifo_full = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop       = dma_wins;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push      = sample && (!fifo_full || pop);
    assign cap_rise  = capture_en && !capture_en_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        wr_idx_d   = wr_idx_q;
        overflow_d = overflow_q;
        wrapped_d  = wrapped_q;
        rvalid_d   = cpu_wins && !cpu_we;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end

        if (sample && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        // A fresh capture session restarts the ring only when nothing stale
        // is queued; otherwise leftovers keep draining contiguously.
        if (cap_rise && !dma_pending) begin
            wr_idx_d = '0;
        end else if (pop) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
            if (wr_idx_q == IDX_W'(BUF_WORDS - 1)) begin
                wrapped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            wr_idx_q     <= '0;
            overflow_q   <= 1'b0;
            wrapped_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            capture_en_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            wr_idx_q     <= wr_idx_d;
            overflow_q   <= overflow_d;
            wrapped_q    <= wrapped_d;
            rvalid_q     <= rvalid_d;
            capture_en_q <= capture_en;
        end
    end

    assign fifo_level = level_q;
    assign wr_idx     = wr_idx_q;
    assign overflow   = overflow_q;
    assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Self-checking bench for dmem_port_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences (fairness/strict priority, overflow,
// ring wrap, reset during a load) and randomized traffic compared each cycle
// against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam logic [31:0] BUF_BASE   = 32'h0000_0100;
    localparam int          BUF_WORDS  = 16;
    localparam int          FIFO_DEPTH = 4;
    localparam int          MAX_STALL  = 3;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrobe;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        capture_en, adc_valid;
    logic [31:0] adc_in;
    logic        mem_en, mem_rw;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrobe;
    logic [31:0] mem_rdata;
    logic [2:0]  fifo_level;
    logic [3:0]  wr_idx;
    logic        overflow, wrapped;

    dmem_port_arbiter #(
        .BUF_BASE  (BUF_BASE),
        .BUF_WORDS (BUF_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wstrobe(cpu_wstrobe),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .capture_en (capture_en),
        .adc_valid  (adc_valid),
        .adc_in     (adc_in),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrobe(mem_wstrobe),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level),
        .wr_idx     (wr_idx),
        .overflow   (overflow),
        .wrapped    (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_fifo [$];
    logic [31:0] m_mem [int];
    int          m_widx  = 0;
    int          m_stall = 0;
    bit          m_ovf = 1'b0, m_wrp = 1'b0, m_rv = 1'b0, m_cap_prev = 1'b0;
    logic [31:0] m_rexp = 32'h0;

    bit          e_gnt, e_dma, e_en, e_rw;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        if (m_mem.exists(k)) return m_mem[k];
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic model_eval();
        bit dma_pend;
        dma_pend = (m_fifo.size() != 0);
        e_gnt = 1'b0; e_dma = 1'b0;
        e_en = 1'b0; e_rw = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
        if (!reset) begin
            if (dma_pend && (!cpu_req || (FAIR && m_stall == MAX_STALL))) e_dma = 1'b1;
            else if (cpu_req) e_gnt = 1'b1;
        end
        if (e_gnt) begin
            e_en = 1'b1; e_rw = cpu_we; e_addr = cpu_addr;
            e_wdata = cpu_wdata; e_strb = cpu_wstrobe;
        end else if (e_dma) begin
            e_en = 1'b1; e_rw = 1'b1; e_addr = BUF_BASE + 32'(m_widx * 4);
            e_wdata = m_fifo[0]; e_strb = 4'hF;
        end
    endtask

    task automatic model_update();
        bit was_empty;
        bit rv_n;
        logic [31:0] w;
        if (reset) begin
            m_fifo.delete();
            m_widx = 0; m_stall = 0; m_ovf = 1'b0; m_wrp = 1'b0;
            m_rv = 1'b0; m_cap_prev = 1'b0;
            return;
        end
        was_empty = (m_fifo.size() == 0);
        rv_n = e_gnt && !cpu_we;
        if (rv_n) m_rexp = mem_rd(cpu_addr);
        if (e_gnt && cpu_we) begin
            w = mem_rd(cpu_addr);
            for (int b = 0; b < 4; b++)
                if (cpu_wstrobe[b]) w[8*b +: 8] = cpu_wdata[8*b +: 8];
            m_mem[int'(cpu_addr >> 2)] = w;
        end
        if (e_dma) begin
            m_mem[int'(e_addr >> 2)] = e_wdata;
            void'(m_fifo.pop_front());
            m_widx = (m_widx + 1) % BUF_WORDS;
            if (m_widx == 0) m_wrp = 1'b1;
        end
        if (was_empty || e_dma) m_stall = 0;
        else if (m_stall < MAX_STALL) m_stall++;
        if (capture_en && adc_valid) begin
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(adc_in);
            else m_ovf = 1'b1;
        end
        if (capture_en && !m_cap_prev && was_empty) m_widx = 0;
        m_cap_prev = capture_en;
        m_rv = rv_n;
    endtask

    task automatic compare_model();
        chk("cpu_gnt",     32'(cpu_gnt),     32'(e_gnt));
        chk("cpu_rvalid",  32'(cpu_rvalid),  32'(m_rv));
        if (m_rv) chk("cpu_rdata", cpu_rdata, m_rexp);
        chk("mem_en",      32'(mem_en),      32'(e_en));
        chk("mem_rw",      32'(mem_rw),      32'(e_rw));
        chk("mem_addr",    mem_addr,         e_addr);
        chk("mem_wdata",   mem_wdata,        e_wdata);
        chk("mem_wstrobe", 32'(mem_wstrobe), 32'(e_strb));
        chk("fifo_level",  32'(fifo_level),  m_fifo.size());
        chk("wr_idx",      32'(wr_idx),      m_widx);
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("wrapped",     32'(wrapped),     32'(m_wrp));
    endtask

    // pre: drive memory read data, settle to mid-cycle, evaluate the model.
    task automatic pre();
        mem_rdata = m_rv ? m_rexp : $urandom();
        #4;
        model_eval();
    endtask

    // post: advance one clock edge and the model with it.
    task automatic post();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_cycle(input bit use_model);
        pre();
        if (use_model) compare_model();
        post();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst, req, we;
        logic [31:0] addr;
        bit          cap, vld;
        logic [31:0] adc;
        bit          chk_en;
        bit          gnt, rv;
        logic [31:0] rdata;
        bit          en, rw;
        logic [31:0] maddr, mwdata;
        logic [3:0]  strb;
        int          lvl, widx;
        bit          ovf, wrp;
    } vec_t;

    function automatic vec_t mk(bit rst, bit req, bit we, logic [31:0] addr,
                                bit cap, bit vld, logic [31:0] adc, bit chk_en,
                                bit gnt, bit rv, logic [31:0] rdata, bit en, bit rw,
                                logic [31:0] maddr, logic [31:0] mwdata,
                                logic [3:0] strb, int lvl, int widx);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.addr = addr;
        v.cap = cap; v.vld = vld; v.adc = adc; v.chk_en = chk_en;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.en = en; v.rw = rw;
        v.maddr = maddr; v.mwdata = mwdata; v.strb = strb;
        v.lvl = lvl; v.widx = widx; v.ovf = 1'b0; v.wrp = 1'b0;
        return v;
    endfunction

    vec_t tbl [10];

    initial begin
        logic [31:0] addr17;
        int          first;

        // Inputs: rst req we addr cap vld adc chk | expected: gnt rv rdata en rw maddr wdata strb lvl widx
        tbl[0] = mk(1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b0, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 0,0);
        tbl[1] = mk(1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b1, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 0,0);
        tbl[2] = mk(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b1, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 0,0);
        tbl[3] = mk(1'b0,1'b1,1'b0,32'h40,1'b0,1'b0,32'h0, 1'b1, 1'b1,1'b0,32'h0, 1'b1,1'b0,32'h40,32'h0,4'h0, 0,0);
        tbl[4] = mk(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b1, 1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0,4'h0, 0,0);
        tbl[5] = mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b1,32'h11111111, 1'b1, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 0,0);
        tbl[6] = mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b1,32'h11111112, 1'b1, 1'b0,1'b0,32'h0, 1'b1,1'b1,32'h100,32'h11111111,4'hF, 1,0);
        tbl[7] = mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b1,32'h11111113, 1'b1, 1'b0,1'b0,32'h0, 1'b1,1'b1,32'h104,32'h11111112,4'hF, 1,1);
        tbl[8] = mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0, 1'b1, 1'b0,1'b0,32'h0, 1'b1,1'b1,32'h108,32'h11111113,4'hF, 1,2);
        tbl[9] = mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0, 1'b1, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 0,3);

        m_mem[int'(32'h40 >> 2)] = 32'hDEADBEEF;
        cpu_wdata = '0; cpu_wstrobe = '0;

        for (int i = 0; i < 10; i++) begin
            reset = tbl[i].rst; cpu_req = tbl[i].req; cpu_we = tbl[i].we;
            cpu_addr = tbl[i].addr; capture_en = tbl[i].cap;
            adc_valid = tbl[i].vld; adc_in = tbl[i].adc;
            pre();
            if (tbl[i].chk_en) begin
                chk("v_gnt",   32'(cpu_gnt),     32'(tbl[i].gnt));
                chk("v_rv",    32'(cpu_rvalid),  32'(tbl[i].rv));
                if (tbl[i].rv) chk("v_rdata", cpu_rdata, tbl[i].rdata);
                chk("v_en",    32'(mem_en),      32'(tbl[i].en));
                chk("v_rw",    32'(mem_rw),      32'(tbl[i].rw));
                chk("v_addr",  mem_addr,         tbl[i].maddr);
                chk("v_wdata", mem_wdata,        tbl[i].mwdata);
                chk("v_strb",  32'(mem_wstrobe), 32'(tbl[i].strb));
                chk("v_level", 32'(fifo_level),  tbl[i].lvl);
                chk("v_widx",  32'(wr_idx),      tbl[i].widx);
                chk("v_ovf",   32'(overflow),    32'(tbl[i].ovf));
                chk("v_wrp",   32'(wrapped),     32'(tbl[i].wrp));
            end
            $display("vec %0d rst=%0b req=%0b cap=%0b vld=%0b : gnt=%0b rv=%0b en=%0b rw=%0b addr=%h wdata=%h lvl=%0d widx=%0d",
                     i, reset, cpu_req, capture_en, adc_valid, cpu_gnt, cpu_rvalid,
                     mem_en, mem_rw, mem_addr, mem_wdata, fifo_level, wr_idx);
            post();
        end

        // ---------------- fairness / strict priority ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        adc_valid = 1'b1; adc_in = 32'hAAAA0001;
        run_cycle(1'b1);
        adc_valid = 1'b0;
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            pre();
            if (mem_en && mem_rw && first == 0) first = k;
            compare_model();
            post();
        end
        cpu_req = 1'b0;
        pre();
`ifdef DMEM_ARB_FAIRNESS_EN
        chk("fair_first_dma_cycle", first, 4);
        chk("fair_drained", 32'(fifo_level), 0);
`else
        chk("strict_no_dma_while_req", first, 0);
        chk("strict_dma_on_release", 32'(mem_en && mem_rw), 1);
        chk("strict_dma_data", mem_wdata, 32'hAAAA0001);
`endif
        $display("seq fairness: first dma cycle=%0d", first);
        compare_model();
        post();

        // ---------------- overflow ----------------
        cpu_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            adc_valid = 1'b1; adc_in = 32'hBB000001 + 32'(k);
            run_cycle(1'b1);
        end
        adc_valid = 1'b0;
        pre();
`ifndef DMEM_ARB_FAIRNESS_EN
        chk("ovf_level_full", 32'(fifo_level), 4);
        chk("ovf_sticky", 32'(overflow), 1);
`endif
        $display("seq overflow: level=%0d overflow=%0b", fifo_level, overflow);
        compare_model();
        post();
        cpu_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pre();
`ifndef DMEM_ARB_FAIRNESS_EN
            chk("ovf_drain_write", 32'(mem_en && mem_rw), 1);
            chk("ovf_drain_data", mem_wdata, 32'hBB000001 + 32'(k));
`endif
            $display("seq overflow drain %0d: addr=%h data=%h", k, mem_addr, mem_wdata);
            compare_model();
            post();
        end

        // ---------------- ring wrap ----------------
        capture_en = 1'b0;
        for (int k = 0; k < 4; k++) run_cycle(1'b1);
        addr17 = 32'hFFFF_FFFF;
        capture_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            adc_valid = (k < 17) ? 1'b1 : 1'b0;
            adc_in = 32'hCC000000 + 32'(k);
            pre();
            if (k == 0) chk("wrap_not_yet", 32'(wrapped), 0);
            if (mem_en && mem_rw && mem_wdata == 32'hCC000010) addr17 = mem_addr;
            compare_model();
            post();
        end
        adc_valid = 1'b0;
        pre();
        chk("wrap_17th_addr", addr17, 32'h100);
        chk("wrap_flag", 32'(wrapped), 1);
        chk("wrap_widx", 32'(wr_idx), 1);
        $display("seq wrap: 17th addr=%h wrapped=%0b widx=%0d", addr17, wrapped, wr_idx);
        compare_model();
        post();

        // ---------------- reset during a load ----------------
        adc_valid = 1'b1; adc_in = 32'hDD000000;
        run_cycle(1'b1);
        reset = 1'b1; adc_valid = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        run_cycle(1'b1);
        reset = 1'b0; cpu_req = 1'b0;
        pre();
        chk("rst_rvalid_cancel", 32'(cpu_rvalid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_widx", 32'(wr_idx), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_wrapped", 32'(wrapped), 0);
        $display("seq midreset: rvalid=%0b level=%0d widx=%0d", cpu_rvalid, fifo_level, wr_idx);
        compare_model();
        post();

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            cpu_req     = ($urandom_range(0, 99) < 45);
            cpu_we      = 1'($urandom_range(0, 1));
            cpu_addr    = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            cpu_wdata   = $urandom();
            cpu_wstrobe = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) capture_en = ~capture_en;
            adc_valid   = ($urandom_range(0, 99) < 40);
            adc_in      = $urandom();
            run_cycle(1'b1);
        end
        $display("random phase done: %0d cycles", 3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
